hazard_scoreboard: RTL
======================

Name: hazard_scoreboard

Overview:
- Parametrised successor to the per-stage forward/stall unit.
- Combines bypass selection with a registered per-register scoreboard of outstanding long-latency writes: loads and, later, mul/div.
- Generates decode stall, a stall-cycle counter and a stall watchdog.
- Sits between IDU and EXU issue; replaces both the forwarding and non-forwarding variants via `FWD_EN`.

Parameters:
- `NREG`, 32, architectural register count: 32 for RV32I, 16 for RV32E. `RW = clog2(NREG)`.
- `XLEN`, 32, data width.
- `FWD_EN`, 1: 1 = bypass EXU/LSU/WB results; 0 = stall on every RAW match.
- `PEND_W`, 2, width of each per-register pending counter. Max outstanding long writes per rd = 2^PEND_W − 1.
- `WDOG`, 1024, consecutive stall cycles before `o_deadlock` is raised.

Ports:
- `i_clk` in 1: clock.
- `i_rst_n` in 1: asynchronous active-low reset.
- `i_valid` in 1: decode slot holds a valid instruction.
- `i_op` in 7: opcode.
- `i_rs1`, `i_rs2` in RW: source registers.
- `i_reg_src1`, `i_reg_src2` in XLEN: register-file read data.
- `i_issue` in 1: decode→EXU handshake fires this cycle (valid & ready).
- `i_issue_rd` in RW, `i_issue_wen` in 1, `i_issue_long` in 1: destination, write enable and long-latency flag of the issuing instruction.
- `i_exu_valid` in 1, `i_exu_rd` in RW, `i_exu_wen` in 1, `i_exu_data` in XLEN: EXU stage result.
- `i_lsu_valid` in 1, `i_lsu_rd` in RW, `i_lsu_wen` in 1, `i_lsu_data` in XLEN: LSU result valid this cycle, including load data.
- `i_wb_valid` in 1, `i_wb_rd` in RW, `i_wb_long` in 1: writeback retires a write.
- `i_flush` in 1: pipeline redirect.
- `o_src1`, `o_src2` out XLEN: bypassed operands.
- `o_stall` out 1: hold decode.
- `o_pend_vec` out NREG: bit r = pending counter of r nonzero.
- `o_stall_cnt` out 32: saturating total stall cycles.
- `o_deadlock` out 1: watchdog flag, sticky.

Behaviour:
- **Reset.** Async, on `i_rst_n` low:
  - all pending counters 0
  - `o_stall_cnt` 0
  - watchdog counter 0
  - `o_deadlock` 0
  - Combinational outputs follow inputs. With the scoreboard empty, `o_stall` is 0 unless an EXU/LSU match applies under `FWD_EN=0`.
- **Source use.**
  - rs1 is used by JALR, OP-IMM, LOAD, SYSTEM, BRANCH, STORE, OP.
  - rs2 is used by BRANCH, STORE, OP.
  - LUI, AUIPC, JAL, FENCE use no sources.
  - x0 never hazards; x0 is never tracked.
- **Scoreboard update.** On `i_issue & i_issue_wen & i_issue_long & i_issue_rd≠0`, increment `cnt[i_issue_rd]`. On `i_wb_valid & i_wb_long`, decrement `cnt[i_wb_rd]`.
  - Same rd both events in one cycle: counter unchanged.
  - Decrement at 0 is ignored.
  - `i_flush` does not touch the scoreboard, since issued instructions always retire.
- **Bypass** (`FWD_EN=1`), per source, priority high to low:
  1. EXU (valid, wen, rd match, rd not pending-long)
  2. LSU (valid, wen, rd match)
  3. register file
- **Stall** (`FWD_EN=1`), per used source s≠0:
  - Hazard if `cnt[s]≠0`, unless an LSU hit on s exists with `cnt[s]==1`. That LSU result satisfies the last outstanding write.
  - Hazard also if `i_issue_long & i_issue_rd==s` in the same cycle (back-to-back load-use).
- **Stall** (`FWD_EN=0`): hazard on any used s matching EXU (valid & wen), LSU (valid & wen), or `cnt[s]≠0`. Operands are register-file data.
- **WAW limit.** `o_stall` is also raised when the decode instruction is long, writes rd≠0, and `cnt[rd]` is at its maximum.
- **Final stall.** `o_stall = i_valid & ~i_flush & (any hazard)`.
- **Statistics.** `o_stall_cnt` increments each cycle `o_stall`=1 and saturates at 0xFFFFFFFF.
- **Watchdog.** The watchdog counts consecutive `o_stall` cycles and clears when `o_stall`=0. On reaching `WDOG`, `o_deadlock` sets and stays set until reset.

Test Plan:
- **Reset defaults.** Reset asserted mid-stream with `cnt[5]=2` → on release: `o_pend_vec`=0, `o_stall_cnt`=0, `o_deadlock`=0, `o_stall`=0 for `add x6,x5,x5`.
- **Load-use stall and LSU forward.** Issue `lw x5` (long), then decode `add x6,x5,x0` → `o_stall`=1. When LSU presents rd=5 data 0xDEADBEEF with `cnt[5]=1` → `o_stall`=0 and `o_src1`=0xDEADBEEF. WB long rd=5 → `o_pend_vec[5]`=0.
- **EXU priority and disabled forwarding.** EXU rd=7 data 0x11 and LSU rd=7 data 0x22 both valid, decode `sub x8,x7,x7` → `o_src1`=`o_src2`=0x11, no stall. Same stimulus with `FWD_EN=0` → `o_stall`=1.
- **Simultaneous issue and writeback.** Issue long rd=3 and WB long rd=3 in the same cycle with `cnt[3]=1` → `cnt[3]` stays 1.
- **WAW saturation.** With `PEND_W=2`, issue 3 long writes to x4, then decode a 4th long write to x4 → `o_stall`=1 until one WB on x4.
- **Flush, x0 and watchdog.** `i_flush`=1 during a hazard → `o_stall`=0, `o_stall_cnt` unchanged. Decode rs1=x0 with EXU rd=0 → `o_stall`=0. Hold a hazard `WDOG` cycles with `WDOG=16` → `o_deadlock`=1 at cycle 16 and stays set after the hazard clears.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - operand bypass, long-latency write scoreboard, decode stall and stall watchdog
// Per-register pending counters track loads/mul/div in flight from issue until writeback.
module hazard_scoreboard #(
  parameter int NREG   = 32,
  parameter int XLEN   = 32,
  parameter bit FWD_EN = 1'b1,
  parameter int PEND_W = 2,
  parameter int WDOG   = 1024,
  localparam int RW    = $clog2(NREG)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  input  logic [6:0]      i_op,
  input  logic [RW-1:0]   i_rs1,
  input  logic [RW-1:0]   i_rs2,
  input  logic [XLEN-1:0] i_reg_src1,
  input  logic [XLEN-1:0] i_reg_src2,
  input  logic            i_issue,
  input  logic [RW-1:0]   i_issue_rd,
  input  logic            i_issue_wen,
  input  logic            i_issue_long,
  input  logic            i_exu_valid,
  input  logic [RW-1:0]   i_exu_rd,
  input  logic            i_exu_wen,
  input  logic [XLEN-1:0] i_exu_data,
  input  logic            i_lsu_valid,
  input  logic [RW-1:0]   i_lsu_rd,
  input  logic            i_lsu_wen,
  input  logic [XLEN-1:0] i_lsu_data,
  input  logic            i_wb_valid,
  input  logic [RW-1:0]   i_wb_rd,
  input  logic            i_wb_long,
  input  logic            i_flush,
  output logic [XLEN-1:0] o_src1,
  output logic [XLEN-1:0] o_src2,
  output logic            o_stall,
  output logic [NREG-1:0] o_pend_vec,
  output logic [31:0]     o_stall_cnt,
  output logic            o_deadlock
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [PEND_W-1:0] CNT_MAX = '1;
  localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);
  localparam int                WD_W    = $clog2(WDOG + 1);
  localparam logic [WD_W-1:0]   WD_MAX  = WD_W'(WDOG);
  localparam logic [WD_W-1:0]   WD_LAST = WD_W'(WDOG - 1);

  logic [PEND_W-1:0] cnt_q [NREG];
  logic [PEND_W-1:0] cnt_d [NREG];
  logic [31:0]       stall_cnt_q, stall_cnt_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;
  logic              dead_q, dead_d;

  logic              use_rs1, use_rs2;
  logic              raw_haz, waw_haz;
  logic [XLEN-1:0]   src_data [2];

  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (i_op)
      OPC_JALR, OPC_OPIMM, OPC_LOAD, OPC_SYSTEM: use_rs1 = 1'b1;
      OPC_BRANCH, OPC_STORE, OPC_OP: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin : bypass
    logic [RW-1:0]     s;
    logic [XLEN-1:0]   rf;
    logic              used, nz, exu_hit, lsu_hit, haz;
    logic [PEND_W-1:0] pend;
    raw_haz     = 1'b0;
    src_data[0] = '0;
    src_data[1] = '0;
    for (int k = 0; k < 2; k++) begin
      s       = (k == 0) ? i_rs1 : i_rs2;
      rf      = (k == 0) ? i_reg_src1 : i_reg_src2;
      used    = (k == 0) ? use_rs1 : use_rs2;
      nz      = (s != '0);
      pend    = cnt_q[s];
      exu_hit = i_exu_valid & i_exu_wen & (i_exu_rd == s) & nz;
      lsu_hit = i_lsu_valid & i_lsu_wen & (i_lsu_rd == s) & nz;
      if (FWD_EN) begin
        // An EXU result for a register still waiting on a long write is stale.
        if (exu_hit && pend == '0)  src_data[k] = i_exu_data;
        else if (lsu_hit)           src_data[k] = i_lsu_data;
        else                        src_data[k] = rf;
        haz = ((pend != '0) & ~(lsu_hit & (pend == CNT_ONE)))
            | (i_issue & i_issue_wen & i_issue_long & (i_issue_rd == s));
      end else begin
        src_data[k] = rf;
        haz         = exu_hit | lsu_hit | (pend != '0);
      end
      raw_haz = raw_haz | (used & nz & haz);
    end
  end

  assign waw_haz     = i_issue_long & i_issue_wen & (i_issue_rd != '0) & (cnt_q[i_issue_rd] == CNT_MAX);
  assign o_stall     = i_valid & ~i_flush & (raw_haz | waw_haz);
  assign o_src1      = src_data[0];
  assign o_src2      = src_data[1];
  assign o_stall_cnt = stall_cnt_q;
  assign o_deadlock  = dead_q;

  always_comb begin
    logic inc, dec;
    for (int r = 0; r < NREG; r++) begin
      inc = i_issue & i_issue_wen & i_issue_long & (i_issue_rd == RW'(r)) & (r != 0);
      dec = i_wb_valid & i_wb_long & (i_wb_rd == RW'(r));
      cnt_d[r] = cnt_q[r];
      if (inc && !dec && cnt_q[r] != CNT_MAX)     cnt_d[r] = cnt_q[r] + CNT_ONE;
      else if (dec && !inc && cnt_q[r] != '0)     cnt_d[r] = cnt_q[r] - CNT_ONE;
      o_pend_vec[r] = (cnt_q[r] != '0);
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    wdog_d      = '0;
    dead_d      = dead_q;
    if (o_stall) begin
      if (stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_d = stall_cnt_q + 32'd1;
      wdog_d = (wdog_q == WD_MAX) ? wdog_q : wdog_q + 1'b1;
      if (wdog_q >= WD_LAST) dead_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
      stall_cnt_q <= '0;
      wdog_q      <= '0;
      dead_q      <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
      stall_cnt_q <= stall_cnt_d;
      wdog_q      <= wdog_d;
      dead_q      <= dead_d;
    end
  end

endmodule
